// File: rtl/bka_nibble_sequencer.sv
// Two-requester 16-bit adder that reuses one 4-bit Brent-Kung slice over four cycles.
// Operations are granted round-robin; each result is held until the consumer accepts it.
module bka_nibble_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [15:0] in0_a,
    input  logic [15:0] in0_b,
    input  logic        in0_cin,
    input  logic        in1_valid,
    output logic        in1_ready,
    input  logic [15:0] in1_a,
    input  logic [15:0] in1_b,
    input  logic        in1_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_cout,
    output logic        out_id
);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic        cout_q, cout_d;
    logic        id_q, id_d;
    logic        last_id_q, last_id_d;
    logic        valid_q, valid_d;

    logic        grant_id;
    logic [3:0]  nib_a, nib_b, nib_sum;
    logic [3:0]  g, p;
    logic        g10, p10, g32, p32, g30, p30, g20, p20;
    logic [4:0]  c;

    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4];

    // Brent-Kung: pairwise up-sweep, root span, then the single down-sweep node for bit 2.
    always_comb begin
        g       = nib_a & nib_b;
        p       = nib_a ^ nib_b;
        g10     = g[1] | (p[1] & g[0]);
        p10     = p[1] & p[0];
        g32     = g[3] | (p[3] & g[2]);
        p32     = p[3] & p[2];
        g30     = g32 | (p32 & g10);
        p30     = p32 & p10;
        g20     = g[2] | (p[2] & g10);
        p20     = p[2] & p10;
        c[0]    = carry_q;
        c[1]    = g[0] | (p[0] & carry_q);
        c[2]    = g10 | (p10 & carry_q);
        c[3]    = g20 | (p20 & carry_q);
        c[4]    = g30 | (p30 & carry_q);
        nib_sum = p ^ c[3:0];
    end

    // Tie goes to the requester that did not win last time.
    always_comb begin
        if (in0_valid && in1_valid) begin
            grant_id = ~last_id_q;
        end else begin
            grant_id = in1_valid;
        end
    end

    assign in0_ready = (state_q == StIdle) && in0_valid && !grant_id;
    assign in1_ready = (state_q == StIdle) && in1_valid && grant_id;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (in0_ready || in1_ready) begin
                    a_d       = grant_id ? in1_a : in0_a;
                    b_d       = grant_id ? in1_b : in0_b;
                    carry_d   = grant_id ? in1_cin : in0_cin;
                    id_d      = grant_id;
                    last_id_d = grant_id;
                    cnt_d     = 2'd0;
                    state_d   = StAdd;
                end
            end
            StAdd: begin
                sum_d[{cnt_q, 2'b00} +: 4] = nib_sum;
                carry_d = c[4];
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cout_d  = c[4];
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            sum_q     <= 16'h0000;
            cnt_q     <= 2'd0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            valid_q   <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_bka_nibble_sequencer.sv
// Directed bench for bka_nibble_sequencer: arbitration, latency, sums, backpressure and reset.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_bka_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in0_valid, in0_ready, in0_cin, in1_valid, in1_ready, in1_cin;
    logic [15:0] in0_a, in0_b, in1_a, in1_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_id;

    int checks = 0;
    int failures = 0;

    bka_nibble_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in0_cin   (in0_cin),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .in1_cin   (in1_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_cout, out_id, out_sum, in0_ready, in1_ready} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b c=%b id=%b sum=%h r0=%b r1=%b want all 0",
                     out_valid, out_cout, out_id, out_sum, in0_ready, in1_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_valid got %b want 0", out_valid);
        end
    endtask

    // in0: FFFF + 0001 exercises carry rippling through every nibble.
    task automatic test_carry_chain;
        in0_valid = 1'b1; in0_a = 16'hFFFF; in0_b = 16'h0001; in0_cin = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL carry_grant got r0=%b r1=%b want 1 0", in0_ready, in1_ready);
        end
        tick();
        in0_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL carry_early_valid cycle=%0d got %b want 0", i, out_valid);
            end
        end
        tick();
        checks++;
        if ({out_valid, out_cout, out_id, out_sum} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL carry_result got v=%b c=%b id=%b sum=%h want v=1 c=1 id=0 sum=0000",
                     out_valid, out_cout, out_id, out_sum);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL carry_retire got %b want 0", out_valid);
        end
    endtask

    task automatic test_in1_sum;
        in1_valid = 1'b1; in1_a = 16'h1234; in1_b = 16'h4321; in1_cin = 1'b1;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL in1_grant got r0=%b r1=%b want 0 1", in0_ready, in1_ready);
        end
        tick();
        in1_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({out_valid, out_cout, out_id, out_sum} !== {1'b1, 1'b0, 1'b1, 16'h5556}) begin
            failures++;
            $display("FAIL in1_result got v=%b c=%b id=%b sum=%h want v=1 c=0 id=1 sum=5556",
                     out_valid, out_cout, out_id, out_sum);
        end
        tick();
    endtask

    // Operands scramble every cycle after accept; valid stays high but must not be re-granted.
    task automatic test_operand_change;
        in0_valid = 1'b1; in0_a = 16'h8000; in0_b = 16'h8000; in0_cin = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            in0_a = 16'($urandom); in0_b = 16'($urandom); in0_cin = 1'($urandom);
            #1;
            checks++;
            if (in0_ready !== 1'b0) begin
                failures++;
                $display("FAIL opchg_ready_in_add cycle=%0d got %b want 0", i, in0_ready);
            end
            tick();
        end
        in0_valid = 1'b0;
        checks++;
        if ({out_valid, out_cout, out_id, out_sum} !== {1'b1, 1'b1, 1'b0, 16'h0001}) begin
            failures++;
            $display("FAIL opchg_result got v=%b c=%b id=%b sum=%h want v=1 c=1 id=0 sum=0001",
                     out_valid, out_cout, out_id, out_sum);
        end
        tick();
    endtask

    task automatic test_backpressure;
        in1_valid = 1'b1; in1_a = 16'h00FF; in1_b = 16'h0F01; in1_cin = 1'b0;
        out_ready = 1'b0;
        tick();
        in1_valid = 1'b0;
        repeat (4) tick();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_cout, out_id, out_sum, in0_ready, in1_ready} !==
                {1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%b c=%b id=%b sum=%h r0=%b r1=%b want v=1 c=0 id=1 sum=1000 r0=0 r1=0",
                         i, out_valid, out_cout, out_id, out_sum, in0_ready, in1_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in0_ready, in1_ready} !== 3'b010) begin
            failures++;
            $display("FAIL bp_retire_regrant got v=%b r0=%b r1=%b want v=0 r0=1 r1=0",
                     out_valid, in0_ready, in1_ready);
        end
        // Withdrawing both before the edge is legal and must not start an operation.
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        in1_valid = 1'b1;
        #1;
        checks++;
        if ({out_valid, in0_ready, in1_ready} !== 3'b001) begin
            failures++;
            $display("FAIL bp_withdraw got v=%b r0=%b r1=%b want v=0 r0=0 r1=1",
                     out_valid, in0_ready, in1_ready);
        end
        in1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        int acc_cyc[8];
        logic acc_id[8];
        logic res_id[8];
        int n_acc = 0;
        int n_res = 0;
        in0_a = 16'h0001; in0_b = 16'h0002; in0_cin = 1'b0;
        in1_a = 16'h1000; in1_b = 16'h2000; in1_cin = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc >= 19) begin
                in0_valid = 1'b0;
                in1_valid = 1'b0;
            end
            #1;
            if ((in0_ready || in1_ready) && n_acc < 8) begin
                acc_cyc[n_acc] = cyc;
                acc_id[n_acc] = in1_ready;
                n_acc++;
            end
            if (out_valid && n_res < 8) begin
                res_id[n_res] = out_id;
                n_res++;
                checks++;
                if ({out_cout, out_sum} !== (out_id ? 17'h03001 : 17'h00003)) begin
                    failures++;
                    $display("FAIL b2b_sum id=%b got c=%b sum=%h want %h", out_id, out_cout,
                             out_sum, out_id ? 17'h03001 : 17'h00003);
                end
            end
            tick();
        end
        checks++;
        if (n_acc !== 4 || n_res !== 4) begin
            failures++;
            $display("FAIL b2b_counts got accepts=%0d results=%0d want 4 4", n_acc, n_res);
        end
        for (int i = 0; i < n_acc && i < 4; i++) begin
            checks++;
            if (acc_id[i] !== 1'(i % 2) || (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 6)) begin
                failures++;
                $display("FAIL b2b_accept idx=%0d got id=%b cyc=%0d want id=%0d spacing 6",
                         i, acc_id[i], acc_cyc[i], i % 2);
            end
        end
        for (int i = 0; i < n_res && i < 4; i++) begin
            checks++;
            if (res_id[i] !== 1'(i % 2)) begin
                failures++;
                $display("FAIL b2b_result_id idx=%0d got %b want %0d", i, res_id[i], i % 2);
            end
        end
    endtask

    task automatic test_reset_mid_add;
        in0_valid = 1'b1; in0_a = 16'hFFFF; in0_b = 16'hFFFF; in0_cin = 1'b1;
        out_ready = 1'b1;
        tick();
        in0_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_cout, out_id, out_sum} !== 19'h0) begin
            failures++;
            $display("FAIL rst_mid_add got v=%b c=%b id=%b sum=%h want all 0",
                     out_valid, out_cout, out_id, out_sum);
        end
        in0_valid = 1'b1; in0_a = 16'h0F0F; in0_b = 16'h00F1; in0_cin = 1'b0;
        in1_valid = 1'b1; in1_a = 16'hAAAA; in1_b = 16'h5555; in1_cin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rst_first_tie got r0=%b r1=%b want 1 0", in0_ready, in1_ready);
        end
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_partial_valid cycle=%0d got %b want 0", i, out_valid);
            end
        end
        tick();
        checks++;
        if ({out_valid, out_cout, out_id, out_sum} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
            failures++;
            $display("FAIL rst_after_result got v=%b c=%b id=%b sum=%h want v=1 c=0 id=0 sum=1000",
                     out_valid, out_cout, out_id, out_sum);
        end
        tick();
    endtask

    initial begin
        in0_valid = 1'b0; in0_a = 16'h0; in0_b = 16'h0; in0_cin = 1'b0;
        in1_valid = 1'b0; in1_a = 16'h0; in1_b = 16'h0; in1_cin = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_in1_sum();
        test_operand_change();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_add();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
